// File: rtl/parking_pkg.sv
// Shared constants for the parking meter button front end: button indices,
// the command priority order and the default debounce length.
package parking_pkg;

  localparam int NUM_BTN = 6;

  // Bit positions of each button inside the internal request vectors.
  localparam int BTN_ADD1 = 0;
  localparam int BTN_ADD2 = 1;
  localparam int BTN_ADD3 = 2;
  localparam int BTN_ADD4 = 3;
  localparam int BTN_RST1 = 4;
  localparam int BTN_RST2 = 5;

  localparam int DEBOUNCE_CYCLES_DEF = 3;

  typedef logic [NUM_BTN-1:0] btn_vec_t;

  // Coin buttons; these are discarded whenever a preset-reset command issues.
  localparam btn_vec_t ADD_MASK = btn_vec_t'(6'b00_1111);

  // Arbitration order, highest priority first.
  localparam logic [2:0] PRIO_ORDER [NUM_BTN] = '{
    3'(BTN_RST1), 3'(BTN_RST2), 3'(BTN_ADD1),
    3'(BTN_ADD2), 3'(BTN_ADD3), 3'(BTN_ADD4)
  };

  // One-hot grant of the highest-priority request, or zero if none.
  function automatic btn_vec_t pick_winner(input btn_vec_t req);
    btn_vec_t win;
    logic     found;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (!found && req[PRIO_ORDER[i[2:0]]]) begin
        win[PRIO_ORDER[i[2:0]]] = 1'b1;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// One raw pushbutton: two-flop synchroniser, run-length debounce filter and
// a single-cycle strobe on each debounced press (0->1 of the stable level).
module button_debounce
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_meta;
  logic             sync_q;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // Synchronise the raw level, then flip the stable level only after
  // DEBOUNCE_CYCLES consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
      stable    <= 1'b0;
      cnt       <= '0;
      press     <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
      press     <= 1'b0;
      if (sync_q == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync_q;
        cnt    <= '0;
        // Only a rising debounced edge is a command; release is silent.
        press  <= sync_q;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_button_conditioner.sv
// Front end of the parking meter: debounces six pushbuttons and issues at
// most one registered single-cycle command per clock, reset commands first.
module parking_button_conditioner
  import parking_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_add,
  input  logic       btn_rst1,
  input  logic       btn_rst2,
  output logic       add1,
  output logic       add2,
  output logic       add3,
  output logic       add4,
  output logic       rst1,
  output logic       rst2,
  output logic       busy
);

  btn_vec_t raw;
  btn_vec_t press;
  btn_vec_t pending;
  btn_vec_t req;
  btn_vec_t win;
  btn_vec_t pending_nxt;
  btn_vec_t cmd;

  assign raw = {btn_rst2, btn_rst1, btn_add};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (raw[g]),
      .press (press[g])
    );
  end

  // Arbitrate over pending commands plus this cycle's fresh presses; a
  // winning reset command wipes every coin request, including new ones.
  always_comb begin
    req         = pending | press;
    win         = pick_winner(req);
    pending_nxt = req & ~win;
    if (|(win & ~ADD_MASK)) begin
      pending_nxt = pending_nxt & ~ADD_MASK;
    end
  end

  // Register the granted command, the surviving pending set and busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
      cmd     <= '0;
      busy    <= 1'b0;
    end else begin
      pending <= pending_nxt;
      cmd     <= win;
      busy    <= |pending_nxt;
    end
  end

  assign add1 = cmd[BTN_ADD1];
  assign add2 = cmd[BTN_ADD2];
  assign add3 = cmd[BTN_ADD3];
  assign add4 = cmd[BTN_ADD4];
  assign rst1 = cmd[BTN_RST1];
  assign rst2 = cmd[BTN_RST2];

endmodule

// File: tb/tb_parking_button_conditioner.sv
// Directed bench for parking_button_conditioner: the stimulus process pushes
// {expected_cycle, expected_command} entries; the monitor pops one per pulse.
module tb_parking_button_conditioner;
  import parking_pkg::*;

  localparam int W = 38;  // {cycle[31:0], command vector[5:0]}

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_add;
  logic       btn_rst1;
  logic       btn_rst2;
  logic       add1, add2, add3, add4, rst1, rst2, busy;

  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  int           cyc;
  logic [5:0]   out_vec;

  parking_button_conditioner dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn_add  (btn_add),
    .btn_rst1 (btn_rst1),
    .btn_rst2 (btn_rst2),
    .add1     (add1),
    .add2     (add2),
    .add3     (add3),
    .add4     (add4),
    .rst1     (rst1),
    .rst2     (rst2),
    .busy     (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  assign out_vec = {rst2, rst1, add4, add3, add2, add1};

  // ---------------- driver tasks ----------------
  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int idx, input int at_cyc);
    logic [5:0] v;
    v = 6'(1 << idx);
    exp_q.push_back({32'(at_cyc), v});
  endtask

  task automatic check_bit(input string name, input logic act, input logic req_v);
    checks++;
    if (act !== req_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, req_v);
    end
  endtask

  task automatic check_word(input string name, input int act, input int req_v);
    checks++;
    if (act != req_v) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, req_v);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (out_vec != 6'b0) begin
      checks++;
      if (!$onehot(out_vec)) begin
        errors++;
        $display("FAIL onehot at cycle %0d: outputs %b", cyc, out_vec);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse at cycle %0d: outputs %b expected none", cyc, out_vec);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (e[5:0] != out_vec || e[37:6] != 32'(cyc)) begin
          errors++;
          $display("FAIL pulse: got %b at cycle %0d expected %b at cycle %0d",
                   out_vec, cyc, e[5:0], e[37:6]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    int m;
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    btn_add  = 4'b0;
    btn_rst1 = 1'b0;
    btn_rst2 = 1'b0;

    // Reset state
    wait_neg(3);
    check_word("reset_outputs", int'(out_vec), 0);
    check_bit("reset_busy", busy, 1'b0);
    rst_n = 1'b1;
    wait_neg(5);

    // Clean press of add2: pulse in the cycle after E5, busy stays low
    k = cyc;
    btn_add[1] = 1'b1;
    expect_pulse(BTN_ADD2, k + 6);
    wait_neg(5);
    check_bit("clean_busy_pre", busy, 1'b0);
    wait_neg(1);
    check_bit("clean_busy_pulse", busy, 1'b0);
    wait_neg(14);
    btn_add[1] = 1'b0;
    wait_neg(10);
    check_bit("clean_busy_after", busy, 1'b0);

    // Bounce shorter than the filter: no pulse, counter back to zero
    btn_add[0] = 1'b1; wait_neg(1);
    btn_add[0] = 1'b0; wait_neg(1);
    btn_add[0] = 1'b1; wait_neg(1);
    btn_add[0] = 1'b0; wait_neg(10);
    check_word("bounce_cnt", int'(dut.g_btn[0].u_deb.cnt), 0);

    // Simultaneous add1 + add3
    k = cyc;
    btn_add[2] = 1'b1;
    btn_add[0] = 1'b1;
    expect_pulse(BTN_ADD1, k + 6);
    expect_pulse(BTN_ADD3, k + 7);
    wait_neg(6);
    check_bit("simul_busy_first", busy, 1'b1);
    wait_neg(1);
    check_bit("simul_busy_second", busy, 1'b0);
    wait_neg(10);
    btn_add = 4'b0;
    wait_neg(10);

    // add4 and rst2 together: only rst2 issues
    k = cyc;
    btn_add[3] = 1'b1;
    btn_rst2   = 1'b1;
    expect_pulse(BTN_RST2, k + 6);
    wait_neg(15);
    btn_add[3] = 1'b0;
    btn_rst2   = 1'b0;
    wait_neg(10);

    // add2 left pending behind add1 when rst1 arrives: add2 dropped
    k = cyc;
    btn_add[0] = 1'b1;
    btn_add[1] = 1'b1;
    expect_pulse(BTN_ADD1, k + 6);
    expect_pulse(BTN_RST1, k + 7);
    wait_neg(1);
    btn_rst1 = 1'b1;
    wait_neg(7);
    check_bit("cancel_busy", busy, 1'b0);
    wait_neg(10);
    btn_add  = 4'b0;
    btn_rst1 = 1'b0;
    wait_neg(10);

    // Long hold then a second press: exactly two rst1 pulses
    k = cyc;
    btn_rst1 = 1'b1;
    expect_pulse(BTN_RST1, k + 6);
    wait_neg(200);
    btn_rst1 = 1'b0;
    wait_neg(10);
    k = cyc;
    btn_rst1 = 1'b1;
    expect_pulse(BTN_RST1, k + 6);
    wait_neg(12);
    btn_rst1 = 1'b0;
    wait_neg(10);

    // Asynchronous reset while a pulse is on the output
    k = cyc;
    btn_add[2] = 1'b1;
    expect_pulse(BTN_ADD3, k + 6);
    wait_neg(6);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_drop_add3", add3, 1'b0);
    check_bit("async_drop_busy", busy, 1'b0);
    btn_add[2] = 1'b0;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(10);

    // Asynchronous reset mid-debounce with add1 held, then re-debounce
    btn_add[0] = 1'b1;
    wait_neg(3);
    #2 rst_n = 1'b0;
    #1;
    check_word("async_mid_outputs", int'(out_vec), 0);
    check_word("async_mid_cnt", int'(dut.g_btn[0].u_deb.cnt), 0);
    wait_neg(3);
    m = cyc;
    rst_n = 1'b1;
    expect_pulse(BTN_ADD1, m + 6);
    wait_neg(20);
    btn_add[0] = 1'b0;
    wait_neg(20);

    // Any expected pulse that never appeared
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_pulse: got none expected %b at cycle %0d", e[5:0], e[37:6]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
